// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it fills.
package imem_pkg;

  // Default instruction-memory depth in 32-bit words; the memory and the loader share it.
  localparam int unsigned MEM_WORDS_DEFAULT = 128;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } imem_ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Control, byte-stream and memory-write signals of the instruction-memory loader.
// master: the host side (boot controller, testbench); slave: the loader itself.
interface imem_loader_if #(
  parameter int unsigned MEM_WORDS = imem_pkg::MEM_WORDS_DEFAULT
) ();

  localparam int unsigned ADDR_WIDTH = $clog2(MEM_WORDS);

  // Load control
  logic                  i_start;
  logic [ADDR_WIDTH:0]   i_num_words;
  logic                  i_abort;

  // Byte stream
  logic                  i_byte_valid;
  logic [7:0]            i_byte;
  logic                  o_byte_ready;

  // Instruction-memory write port
  logic                  o_we;
  logic [31:0]           o_waddr;
  logic [31:0]           o_wdata;

  // Status
  logic                  o_cpu_hold;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;

  modport master (
    output i_start, i_num_words, i_abort, i_byte_valid, i_byte,
    input  o_byte_ready, o_we, o_waddr, o_wdata, o_cpu_hold, o_busy, o_done, o_error
  );

  modport slave (
    input  i_start, i_num_words, i_abort, i_byte_valid, i_byte,
    output o_byte_ready, o_we, o_waddr, o_wdata, o_cpu_hold, o_busy, o_done, o_error
  );

endinterface

// File: rtl/byte_word_packer.sv
// Packs accepted bytes into little-endian 32-bit words. word_valid_o fires combinationally
// on the accept that completes a word, with word_o already carrying that final byte.
module byte_word_packer
  import imem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam int unsigned CntWidth = $clog2(BYTES_PER_WORD);
  localparam logic [CntWidth-1:0] LastByte = CntWidth'(BYTES_PER_WORD - 1);

  logic [CntWidth-1:0] byte_cnt_q;
  logic [31:0]         shift_q;

  // Byte counter and assembly register; clear wins over a same-cycle accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else if (clear_i) begin
      byte_cnt_q <= '0;
    end else if (accept_i) begin
      shift_q[{byte_cnt_q, 3'b000} +: 8] <= byte_i;
      byte_cnt_q                         <= byte_cnt_q + CntWidth'(1);
    end
  end

  // Completed word: the top byte comes straight from the input on the final accept.
  always_comb begin
    word_valid_o   = accept_i && (byte_cnt_q == LastByte);
    word_o         = shift_q;
    word_o[31:24]  = byte_i;
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: collects a byte stream, emits one write per 32-bit word
// and holds the core until a load completes.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input logic          i_clk,
  input logic          i_rst_n,
  imem_loader_if.slave bus
);

  localparam int unsigned ADDR_WIDTH = $clog2(MEM_WORDS);
  localparam int unsigned CountWidth = ADDR_WIDTH + 1;

  imem_ld_state_t          state_q;
  logic [ADDR_WIDTH-1:0]   word_idx_q;
  logic [CountWidth-1:0]   count_q;
  logic                    ready_q;
  logic                    we_q;
  logic [31:0]             waddr_q;
  logic [31:0]             wdata_q;
  logic                    hold_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;

  logic                    byte_accept;
  logic                    pk_clear;
  logic                    count_ok;
  logic                    last_word;
  logic                    word_valid;
  logic [31:0]             word;

  // Handshake qualification, packer clear and start/last-word decode.
  always_comb begin
    byte_accept = bus.i_byte_valid && ready_q && !bus.i_abort;
    pk_clear    = bus.i_abort || (bus.i_start && !busy_q);
    count_ok    = (bus.i_num_words != '0) && (32'(bus.i_num_words) <= MEM_WORDS);
    last_word   = ({1'b0, word_idx_q} == (count_q - CountWidth'(1)));
  end

  byte_word_packer u_packer (
    .clk_i        (i_clk),
    .rst_ni       (i_rst_n),
    .clear_i      (pk_clear),
    .accept_i     (byte_accept),
    .byte_i       (bus.i_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Load FSM with registered outputs; we_q is a one-cycle pulse covering the WRITE state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      word_idx_q <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (bus.i_start) begin
            done_q <= 1'b0;
            hold_q <= 1'b1;
            if (count_ok) begin
              state_q    <= StRecv;
              word_idx_q <= '0;
              count_q    <= bus.i_num_words;
              error_q    <= 1'b0;
              ready_q    <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= StIdle;
              error_q <= 1'b1;
            end
          end
        end
        StRecv: begin
          if (bus.i_abort) begin
            state_q <= StIdle;
            error_q <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b1;
          end else if (word_valid) begin
            state_q <= StWrite;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            waddr_q <= 32'({word_idx_q, 2'b00});
            wdata_q <= word;
          end
        end
        StWrite: begin
          if (bus.i_abort) begin
            state_q <= StIdle;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            hold_q  <= 1'b1;
          end else if (last_word) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            hold_q  <= 1'b0;
          end else begin
            state_q    <= StRecv;
            word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
            ready_q    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // An abort during WRITE must suppress the pulse already registered for that cycle.
  assign bus.o_we         = we_q && !bus.i_abort;
  assign bus.o_byte_ready = ready_q;
  assign bus.o_waddr      = waddr_q;
  assign bus.o_wdata      = wdata_q;
  assign bus.o_cpu_hold   = hold_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected writes into a queue and an
// independent monitor pops and compares every write pulse.
module tb_imem_loader;

  localparam int unsigned MemWords = 128;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  int   expected_writes = 0;
  wr_t  exp_q[$];

  imem_loader_if #(.MEM_WORDS(MemWords)) bus ();

  imem_loader #(.MEM_WORDS(MemWords)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse is checked against the next queued expectation.
  always @(negedge clk) begin
    if (bus.o_we === 1'b1) begin
      wr_t e;
      writes++;
      check1("ready_low_on_write", bus.o_byte_ready, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write at %0t",
                 bus.o_waddr, bus.o_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check32("waddr", bus.o_waddr, e.addr);
        check32("wdata", bus.o_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_load(input int n);
    bus.i_start     = 1'b1;
    bus.i_num_words = 8'(n);
    tick();
    bus.i_start     = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < gap; i++) begin
      bus.i_byte_valid = 1'b0;
      tick();
    end
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = b;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.o_byte_ready;
      tick();
    end
    bus.i_byte_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got no ready expected ready within 50 cycles at %0t", $time);
    end
  endtask

  // Queue the expected write, send the word LSB first, then confirm the pulse follows at once.
  task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input int maxgap);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
    expected_writes++;
    for (int k = 0; k < 4; k++) begin
      send_byte(data[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    check1("we_latency", bus.o_we, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.o_done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check1("done", bus.o_done, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_hold"}, bus.o_cpu_hold, 1'b1);
    check1({tag, "_we"}, bus.o_we, 1'b0);
    check1({tag, "_done"}, bus.o_done, 1'b0);
    check1({tag, "_error"}, bus.o_error, 1'b0);
    check1({tag, "_busy"}, bus.o_busy, 1'b0);
    check1({tag, "_ready"}, bus.o_byte_ready, 1'b0);
    check32({tag, "_waddr"}, bus.o_waddr, 32'h0);
    check32({tag, "_wdata"}, bus.o_wdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b1;
    bus.i_start      = 1'b0;
    bus.i_num_words  = '0;
    bus.i_abort      = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = '0;
    #2 rst_n = 1'b0;
    #10;
    check_reset_outputs("rst");
    tick();
    rst_n = 1'b1;
    idle(2);

    // Single word
    start_load(1);
    send_word(32'h0, 32'h0000_0013, 0);
    wait_done();
    check1("single_hold", bus.o_cpu_hold, 1'b0);
    check1("single_busy", bus.o_busy, 1'b0);
    check1("single_error", bus.o_error, 1'b0);

    // Reload from DONE
    start_load(2);
    check1("reload_done_clr", bus.o_done, 1'b0);
    check1("reload_hold", bus.o_cpu_hold, 1'b1);
    check1("reload_busy", bus.o_busy, 1'b1);
    send_word(32'h0, 32'h1122_3344, 0);
    send_word(32'h4, 32'hDEAD_BEEF, 0);
    wait_done();
    check1("reload_release", bus.o_cpu_hold, 1'b0);

    // Bad counts
    start_load(0);
    check1("bad0_error", bus.o_error, 1'b1);
    check1("bad0_done", bus.o_done, 1'b0);
    check1("bad0_hold", bus.o_cpu_hold, 1'b1);
    check1("bad0_busy", bus.o_busy, 1'b0);
    check1("bad0_ready", bus.o_byte_ready, 1'b0);
    idle(5);
    start_load(129);
    check1("bad129_error", bus.o_error, 1'b1);
    check1("bad129_hold", bus.o_cpu_hold, 1'b1);
    check1("bad129_busy", bus.o_busy, 1'b0);
    idle(5);

    // Abort after six bytes, alongside a valid seventh byte
    start_load(4);
    check1("abort_err_clr", bus.o_error, 1'b0);
    send_word(32'h0, 32'h0302_0100, 0);
    send_byte(8'h04, 0);
    send_byte(8'h05, 0);
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = 8'h06;
    bus.i_abort      = 1'b1;
    tick();
    bus.i_abort      = 1'b0;
    bus.i_byte_valid = 1'b0;
    check1("abort_error", bus.o_error, 1'b1);
    check1("abort_busy", bus.o_busy, 1'b0);
    check1("abort_hold", bus.o_cpu_hold, 1'b1);
    check1("abort_ready", bus.o_byte_ready, 1'b0);
    idle(8);
    start_load(1);
    send_word(32'h0, 32'hCAFE_F00D, 0);
    wait_done();

    // Abort landing on the WRITE cycle suppresses that write
    start_load(2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    bus.i_abort = 1'b1;
    #1;
    check1("write_abort_we", bus.o_we, 1'b0);
    tick();
    bus.i_abort = 1'b0;
    check1("write_abort_error", bus.o_error, 1'b1);
    check1("write_abort_busy", bus.o_busy, 1'b0);
    idle(4);

    // Full depth with random gaps on the byte stream
    start_load(128);
    for (int i = 0; i < 128; i++) begin
      logic [31:0] d;
      d = {~8'(i), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      send_word(32'(4 * i), d, 2);
    end
    wait_done();
    check1("full_release", bus.o_cpu_hold, 1'b0);

    // Asynchronous reset mid-load drops the partial word
    start_load(3);
    send_word(32'h0, 32'h0123_4567, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    start_load(1);
    send_word(32'h0, 32'h89AB_CDEF, 0);
    wait_done();

    idle(5);
    check32("queue_empty", 32'(exp_q.size()), 32'h0);
    check32("write_count", 32'(writes), 32'(expected_writes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
